// File: rtl/ahb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ahb_pkg
// Purpose  : AHB-Lite encodings and burst-master state/helper definitions.
// Revision : 1.0 - initial release
// ============================================================================
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE = 2'b00;
    localparam logic [1:0] HTRANS_BUSY = 2'b01;
    localparam logic [1:0] HTRANS_NSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ  = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR4  = 3'b011;
    localparam logic [2:0] HBURST_INCR8  = 3'b101;
    localparam logic [2:0] HBURST_INCR16 = 3'b111;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    localparam logic [2:0] HSIZE_WORD = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_ERR  = 2'd3
    } state_e;

    // Unsupported burst codes collapse to SINGLE so the bus never sees them.
    function automatic logic [2:0] burst_norm(input logic [2:0] code);
        case (code)
            HBURST_INCR4, HBURST_INCR8, HBURST_INCR16: return code;
            default:                                   return HBURST_SINGLE;
        endcase
    endfunction

    function automatic logic [4:0] burst_beats(input logic [2:0] code);
        case (code)
            HBURST_INCR4:  return 5'd4;
            HBURST_INCR8:  return 5'd8;
            HBURST_INCR16: return 5'd16;
            default:       return 5'd1;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/ahb_burst_master_if.sv
`default_nettype none
// ============================================================================
// Module   : ahb_burst_master_if
// Purpose  : AHB-Lite master/slave signal bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface ahb_burst_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [1:0]        htrans;
    logic [ADDR_W-1:0] haddr;
    logic              hwrite;
    logic [2:0]        hsize;
    logic [2:0]        hburst;
    logic [DATA_W-1:0] hwdata;
    logic              hready;
    logic [1:0]        hresp;
    logic [DATA_W-1:0] hrdata;

    modport master (
        output htrans, haddr, hwrite, hsize, hburst, hwdata,
        input  hready, hresp, hrdata
    );

    modport slave (
        input  htrans, haddr, hwrite, hsize, hburst, hwdata,
        output hready, hresp, hrdata
    );
endinterface
`default_nettype wire

// File: rtl/ahb_burst_master.sv
`default_nettype none
// ============================================================================
// Module   : ahb_burst_master
// Purpose  : Command-driven AHB-Lite master issuing SINGLE/INCR4/8/16 bursts.
// Revision : 1.0 - initial release
// ============================================================================
module ahb_burst_master
    import ahb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              hclk,
    input  logic              hresetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [2:0]        cmd_burst,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_pop,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              done,
    output logic              err,
    ahb_burst_master_if.master bus
);

    state_e            r_state;
    state_e            w_state_next;
    logic              r_first;
    logic              r_hwrite;
    logic              r_dph_valid;
    logic [2:0]        r_hburst;
    logic [4:0]        r_addr_left;
    logic [ADDR_W-1:0] r_haddr;
    logic [DATA_W-1:0] r_hwdata;
    logic              r_rd_valid;
    logic [DATA_W-1:0] r_rd_data;
    logic              r_done;
    logic              r_err;

    logic w_accept;
    logic w_addr_acc;
    logic w_dph_done;
    logic w_err_first;

    assign cmd_ready   = (r_state == ST_IDLE);
    assign w_accept    = cmd_valid & cmd_ready;
    assign w_addr_acc  = (r_state == ST_ADDR) & bus.hready;
    assign w_dph_done  = r_dph_valid & bus.hready;
    // First cycle of the two-cycle ERROR response: slave stalls with ERROR.
    assign w_err_first = r_dph_valid & ~bus.hready & (bus.hresp == HRESP_ERROR);
    assign wr_pop      = w_addr_acc & r_hwrite;

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) r_state <= ST_IDLE;
        else          r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        bus.htrans   = HTRANS_IDLE;
        case (r_state)
            ST_IDLE: if (cmd_valid) w_state_next = ST_ADDR;
            ST_ADDR: begin
                bus.htrans = r_first ? HTRANS_NSEQ : HTRANS_SEQ;
                if (w_err_first)                             w_state_next = ST_ERR;
                else if (w_addr_acc && r_addr_left == 5'd1)  w_state_next = ST_DATA;
            end
            ST_DATA: begin
                if (w_err_first)     w_state_next = ST_ERR;
                else if (w_dph_done) w_state_next = ST_IDLE;
            end
            ST_ERR:  w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_first     <= 1'b0;
            r_hwrite    <= 1'b0;
            r_dph_valid <= 1'b0;
            r_hburst    <= HBURST_SINGLE;
            r_addr_left <= 5'd0;
            r_haddr     <= '0;
            r_hwdata    <= '0;
            r_rd_valid  <= 1'b0;
            r_rd_data   <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            if (w_accept) begin
                r_first     <= 1'b1;
                r_hwrite    <= cmd_write;
                r_hburst    <= burst_norm(cmd_burst);
                r_addr_left <= burst_beats(burst_norm(cmd_burst));
                r_haddr     <= cmd_addr & ~ADDR_W'(3);
            end else if (w_addr_acc) begin
                r_first     <= 1'b0;
                r_addr_left <= r_addr_left - 5'd1;
                r_haddr     <= r_haddr + ADDR_W'(4);
            end

            // Outstanding data phase follows each accepted address phase; an
            // ERROR cancels it so the erroring beat never reports read data.
            if (w_err_first)       r_dph_valid <= 1'b0;
            else if (bus.hready)   r_dph_valid <= w_addr_acc;

            if (wr_pop) r_hwdata <= wr_data;

            r_rd_valid <= w_dph_done & ~r_hwrite;
            if (w_dph_done && !r_hwrite) r_rd_data <= bus.hrdata;

            r_done <= ((r_state == ST_DATA) && w_dph_done) || (r_state == ST_ERR);
            r_err  <= (r_state == ST_ERR);
        end
    end

    assign bus.haddr  = r_haddr;
    assign bus.hwrite = r_hwrite;
    assign bus.hsize  = HSIZE_WORD;
    assign bus.hburst = r_hburst;
    assign bus.hwdata = r_hwdata;
    assign rd_valid   = r_rd_valid;
    assign rd_data    = r_rd_data;
    assign done       = r_done;
    assign err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ahb_burst_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_ahb_burst_master
// Purpose  : Self-checking bench: bench-side SRAM slave plus transaction model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ahb_burst_master;
    import ahb_pkg::*;

    logic        hclk = 1'b0;
    logic        hresetn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [2:0]  cmd_burst = '0;
    logic [31:0] wr_data = '0;
    logic        cmd_ready, wr_pop, rd_valid, done, err;
    logic [31:0] rd_data;

    ahb_burst_master_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    ahb_burst_master #(.ADDR_W(32), .DATA_W(32)) dut (
        .hclk      (hclk),
        .hresetn   (hresetn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_burst (cmd_burst),
        .wr_data   (wr_data),
        .wr_pop    (wr_pop),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .done      (done),
        .err       (err),
        .bus       (bus)
    );

    always #5 hclk = ~hclk;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [2:0]  code;
        int          eb;     // data-phase beat that gets ERROR (-1 none)
        int          wb;     // data-phase beat with directed wait states
        int          wl;
        bit          rnd;    // random wait states
        logic [31:0] d0;
        logic [31:0] dstep;
    } plan_t;

    plan_t       pq[$];
    plan_t       cur;
    int          checks = 0, errors = 0;
    bit          in_flight = 0, dp_pend = 0, done_due = 0, err_due = 0, rdv_due = 0;
    int          n = 0, k = 0, dp_beat = 0, dp_waits = 0, err_state = 0, cyc = 0, acc_cyc = 0;
    logic [31:0] base = '0, dp_addr = '0, rdv_data = '0;
    logic [2:0]  code_n = '0;
    logic [31:0] mem [0:4095];
    logic [31:0] wd [0:15];
    int          lat_log[$];
    bit          err_log[$];
    logic [31:0] rd_log[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [2:0] norm_code(input logic [2:0] c);
        return (c == 3'b011 || c == 3'b101 || c == 3'b111) ? c : 3'b000;
    endfunction

    function automatic int n_beats(input logic [2:0] c);
        case (c)
            3'b011:  return 4;
            3'b101:  return 8;
            3'b111:  return 16;
            default: return 1;
        endcase
    endfunction

    // Slave + reference model: picks the cycle's responses, checks DUT
    // outputs, then advances the transaction state across the coming edge.
    initial begin : model
        bit addr_act;
        for (int i = 0; i < 4096; i++) mem[i] = '0;
        bus.hready = 1'b1; bus.hresp = 2'b00; bus.hrdata = '0;
        forever begin
            @(negedge hclk);
            cyc++;
            if (!hresetn) begin
                in_flight = 0; dp_pend = 0; done_due = 0; rdv_due = 0; err_state = 0;
                cmd_valid = 0; bus.hready = 1'b1; bus.hresp = 2'b00;
                #1;
                chk("reset_vals",
                    {bus.htrans, bus.haddr, bus.hwrite, bus.hsize, bus.hburst, bus.hwdata,
                     cmd_ready, rd_valid, rd_data, done, err, wr_pop},
                    {2'b00, 32'h0, 1'b0, 3'b010, 3'b000, 32'h0,
                     1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0});
                continue;
            end
            bus.hready = 1'b1; bus.hresp = 2'b00; bus.hrdata = $urandom;
            if (dp_pend) begin
                if (err_state == 1)                             err_state = 2;
                else if (err_state == 0 && dp_beat == cur.eb)   err_state = 1;
                if (err_state == 1) begin
                    bus.hready = 1'b0; bus.hresp = HRESP_ERROR;
                end else if (err_state == 2) begin
                    bus.hready = 1'b1; bus.hresp = HRESP_ERROR;
                end else if (dp_beat == cur.wb && dp_waits < cur.wl) begin
                    bus.hready = 1'b0; dp_waits++;
                end else if (cur.rnd && $urandom_range(0, 3) == 0) begin
                    bus.hready = 1'b0;
                end
                if (!cur.wr) bus.hrdata = mem[dp_addr[13:2]];
            end
            cmd_valid = 0; cmd_write = 1'($urandom); cmd_addr = $urandom; cmd_burst = 3'($urandom);
            if (!in_flight && pq.size() > 0 && $urandom_range(0, 1) == 1) begin
                cmd_valid = 1; cmd_write = pq[0].wr; cmd_addr = pq[0].addr; cmd_burst = pq[0].code;
            end
            wr_data = (in_flight && cur.wr && k < n) ? wd[k] : $urandom;
            #1;
            addr_act = in_flight && k < n && err_state != 2;
            chk("cmd_ready", cmd_ready, !in_flight);
            chk("done", done, done_due);
            if (done_due) chk("err", err, err_due);
            chk("rd_valid", rd_valid, rdv_due);
            if (rdv_due) chk("rd_data", rd_data, rdv_data);
            chk("hsize", bus.hsize, 3'b010);
            chk("wr_pop", wr_pop, addr_act && cur.wr && bus.hready);
            if (err_state != 1) begin
                chk("htrans", bus.htrans, addr_act ? (k == 0 ? 2'b10 : 2'b11) : 2'b00);
                if (addr_act) begin
                    chk("haddr", bus.haddr, base + 32'(4 * k));
                    chk("hburst", bus.hburst, code_n);
                    chk("hwrite", bus.hwrite, cur.wr);
                end
            end
            if (dp_pend && cur.wr) chk("hwdata", bus.hwdata, wd[dp_beat]);

            done_due = 0; rdv_due = 0;
            if (dp_pend && bus.hready) begin
                dp_pend = 0;
                if (err_state == 2) begin
                    err_state = 0; done_due = 1; err_due = 1; in_flight = 0;
                end else begin
                    if (cur.wr) mem[dp_addr[13:2]] = bus.hwdata;
                    else begin
                        rdv_due = 1; rdv_data = bus.hrdata; rd_log.push_back(bus.hrdata);
                    end
                    if (dp_beat == n - 1) begin done_due = 1; err_due = 0; in_flight = 0; end
                end
                if (done_due) begin lat_log.push_back(cyc + 1 - acc_cyc); err_log.push_back(err_due); end
            end
            if (addr_act && bus.hready && err_state == 0) begin
                dp_pend = 1; dp_beat = k; dp_addr = base + 32'(4 * k); dp_waits = 0; k++;
            end
            if (cmd_valid) begin
                cur = pq.pop_front();
                in_flight = 1; k = 0; err_state = 0; acc_cyc = cyc;
                code_n = norm_code(cur.code);
                n = n_beats(code_n);
                base = {cur.addr[31:2], 2'b00};
                for (int i = 0; i < 16; i++) wd[i] = cur.d0 + 32'(i) * cur.dstep;
            end
        end
    end

    task automatic push(input bit wr, input logic [31:0] a, input logic [2:0] c, input int eb,
                        input int wb, input int wl, input bit rnd, input logic [31:0] d0,
                        input logic [31:0] dstep);
        plan_t p;
        p.wr = wr; p.addr = a; p.code = c; p.eb = eb; p.wb = wb; p.wl = wl;
        p.rnd = rnd; p.d0 = d0; p.dstep = dstep;
        pq.push_back(p);
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((pq.size() != 0 || in_flight || done_due || rdv_due) && t < 20000) begin
            @(posedge hclk); t++;
        end
        if (t >= 20000) chk("idle_timeout", 1, 0);
    endtask

    task automatic clear_logs();
        lat_log.delete(); err_log.delete(); rd_log.delete();
    endtask

    initial begin : main
        int t;
        repeat (3) @(posedge hclk);
        #2 hresetn = 1'b1;
        repeat (10) @(posedge hclk);

        clear_logs();
        push(1, 32'h10, 3'b000, -1, -1, 0, 0, 32'hA5A5_0001, 0);
        wait_idle();
        chk("wr_single_lat", lat_log.size() > 0 ? lat_log[0] : -1, 3);
        chk("wr_single_err", err_log.size() > 0 ? err_log[0] : 1'b1, 0);

        clear_logs();
        push(0, 32'h10, 3'b000, -1, -1, 0, 0, 0, 0);
        wait_idle();
        chk("rd_single_data", rd_log.size() > 0 ? rd_log[0] : 32'hx, 32'hA5A5_0001);
        chk("rd_single_lat", lat_log.size() > 0 ? lat_log[0] : -1, 3);

        clear_logs();
        push(1, 32'h100, 3'b011, -1, -1, 0, 0, 32'd1, 32'd1);
        wait_idle();
        chk("wr_incr4_lat", lat_log.size() > 0 ? lat_log[0] : -1, 6);

        clear_logs();
        push(0, 32'h100, 3'b011, -1, -1, 0, 0, 0, 0);
        wait_idle();
        chk("rd_incr4_cnt", rd_log.size(), 4);
        for (int i = 0; i < 4 && i < rd_log.size(); i++) chk("rd_incr4_data", rd_log[i], 32'(i + 1));
        chk("rd_incr4_lat", lat_log.size() > 0 ? lat_log[0] : -1, 6);

        clear_logs();
        push(0, 32'h100, 3'b101, -1, 2, 2, 0, 0, 0);
        wait_idle();
        chk("rd_incr8_cnt", rd_log.size(), 8);
        chk("rd_incr8_lat", lat_log.size() > 0 ? lat_log[0] : -1, 12);
        chk("rd_incr8_done", lat_log.size(), 1);

        clear_logs();
        push(0, 32'h400, 3'b111, 1, -1, 0, 0, 0, 0);
        wait_idle();
        chk("rd_err_cnt", rd_log.size(), 1);
        chk("rd_err_flag", err_log.size() > 0 ? err_log[0] : 1'b0, 1);
        chk("rd_err_lat", lat_log.size() > 0 ? lat_log[0] : -1, 5);

        clear_logs();
        push(1, 32'h200, 3'b101, -1, -1, 0, 0, $urandom, 32'h0101_0101);
        t = 0;
        while (!(in_flight && k >= 3) && t < 200) begin @(posedge hclk); t++; end
        if (t >= 200) chk("midburst_timeout", 1, 0);
        @(posedge hclk);
        #2 hresetn = 1'b0;
        repeat (3) @(posedge hclk);
        #2 hresetn = 1'b1;
        repeat (2) @(posedge hclk);
        chk("midburst_no_done", lat_log.size(), 0);

        clear_logs();
        push(0, 32'h10, 3'b000, -1, -1, 0, 0, 0, 0);
        wait_idle();
        chk("post_rst_data", rd_log.size() > 0 ? rd_log[0] : 32'hx, 32'hA5A5_0001);
        chk("post_rst_lat", lat_log.size() > 0 ? lat_log[0] : -1, 3);

        for (int i = 0; i < 40; i++) begin
            logic [2:0] c;
            int nb, blk, off, eb;
            c   = 3'($urandom_range(0, 7));
            nb  = n_beats(norm_code(c));
            blk = $urandom_range(0, 15);
            off = $urandom_range(0, 256 - nb);
            eb  = ($urandom_range(0, 5) == 0) ? $urandom_range(0, nb - 1) : -1;
            push(1'($urandom), 32'(blk * 1024 + off * 4 + $urandom_range(0, 3)), c, eb,
                 -1, 0, 1, $urandom, $urandom | 32'h1);
        end
        wait_idle();
        repeat (3) @(posedge hclk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ahb_burst_master.md
# ahb_burst_master

Command-driven AHB-Lite master that converts single-word read/write burst commands into AHB transfers. It drives the slave port of the AHB SRAM subsystem (word space 0x0000_0000–0x0000_3FFC). Write data is pulled from a first-word-fall-through source; read data is returned on a valid strobe. Each command ends with a completion pulse and an error flag.

## Interface
- ADDR_W, 32, AHB address width
- DATA_W, 32, AHB data width; only 32 supported
- hclk  in  1  AHB clock; everything is on the rising edge
- hresetn  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE; a command is accepted on the edge where cmd_valid & cmd_ready
- cmd_write  in  1  1 = write burst, 0 = read burst
- cmd_addr  in  ADDR_W  start byte address; bits [1:0] are forced to 0
- cmd_burst  in  3  000 SINGLE, 011 INCR4, 101 INCR8, 111 INCR16; any other code is treated as SINGLE
- wr_data  in  32  next write word (FWFT head)
- wr_pop  out  1  combinational; high when a write address phase is accepted (htrans NSEQ/SEQ, hwrite = 1, hready = 1); the source advances on that edge
- rd_valid  out  1  registered strobe, one per completed read beat
- rd_data  out  32  read word, valid with rd_valid
- done  out  1  one-cycle pulse when the command terminates
- err  out  1  valid with done; 1 if the burst ended on an ERROR response
- htrans, haddr, hwrite, hsize, hburst, hwdata  out  2/ADDR_W/1/3/3/32  AHB master outputs
- hready  in  1  AHB ready
- hresp  in  2  AHB response; 00 OKAY, 01 ERROR
- hrdata  in  32  AHB read data

## Operation
- **States:** IDLE, ADDR, DATA, ERR.
- **IDLE:** drive htrans = IDLE (00). On accept, latch cmd_write and cmd_burst, set beats = 1/4/8/16, load the beat counter (5 bits), then go to ADDR.
- **ADDR (address phases):**
  - First beat: htrans = NSEQ (10); later beats: SEQ (11).
  - haddr += 4 per accepted beat; incrementing only, never wrapping.
  - hsize is fixed at 010; hburst holds the latched code; hwrite holds the latched direction.
  - After the last address phase is accepted, go to DATA.
- **DATA:** htrans = IDLE. Wait for the final data phase to complete, then pulse done with err = 0 and return to IDLE.
- **Write data:** hwdata is registered from wr_data on every edge where wr_pop is high, so it lines up with that beat's data phase.
- **Read data:** on every edge that completes a read data phase (hready = 1 with an outstanding read beat), capture hrdata into rd_data and set rd_valid.
- **Wait states:** while hready = 0, htrans, haddr, hwrite, hburst and hwdata hold, and no counter advances.
- **ERROR response (hresp = 01, hready = 0 in the first cycle):**
  - In the second cycle, drive htrans = IDLE and cancel all remaining beats.
  - The erroring beat produces no rd_valid.
  - Move to ERR, then pulse done with err = 1 and return to IDLE.
- **1 KB boundaries:** the caller guarantees that no INCR burst crosses one; the master does not check.
- **Reset:** asserting hresetn mid-burst aborts the burst with no done pulse. Reset values:
  - htrans 00, haddr 0, hwrite 0, hsize 010, hburst 000, hwdata 0
  - cmd_ready 1, rd_valid 0, rd_data 0, done 0, err 0, state IDLE

## Timing
- Command accepted at edge T: the first NSEQ is driven in cycle T+1.
- Zero-wait INCRn:
  - Address phases in cycles T+1..T+n.
  - Data phases in cycles T+2..T+n+1.
  - rd_valid in cycles T+3..T+n+2.
  - done in cycle T+n+2.
- Read SINGLE, zero wait: done at T+3, coincident with the only rd_valid.
- Write SINGLE: done at T+3.
- A burst that ends on ERROR has done one cycle after the second ERROR cycle.
- Each wait state delays all later events by exactly one cycle.
- cmd_ready returns high in the cycle done is high, so back-to-back commands have exactly 2 idle bus cycles between them.
- Only one command is in flight at a time; there is no overlap of address phases across commands.

## Structure
- **Shared package `ahb_pkg`:** HTRANS_IDLE/BUSY/NSEQ/SEQ, HBURST_SINGLE/INCR4/INCR8/INCR16, HRESP_OKAY/ERROR, HSIZE_WORD, and the state encoding.
- **No sub-module:** beat counting, address increment and data alignment live in the one module. The integration top connects it to the AHB SRAM subsystem with no glue.

## Test plan
- **Reset idle:** hold hresetn = 0, release, leave cmd_valid = 0 for 10 cycles -> every output at its reset value, htrans = 00 throughout.
- **Single write then read:**
  - SINGLE write 0x10 with data 0xA5A5_0001 -> one NSEQ, one wr_pop, done with err = 0.
  - SINGLE read 0x10 -> rd_data = 0xA5A5_0001 with done in the same cycle.
- **INCR4 write/read-back:**
  - INCR4 write at 0x100 with data 1..4 -> htrans NSEQ,SEQ,SEQ,SEQ; haddr 0x100/104/108/10C; hburst = 011; 4 wr_pop.
  - INCR4 read of the same range -> rd_data 1,2,3,4 in consecutive cycles, done on the 4th.
- **INCR8 read with wait states:** hold hready = 0 for 2 cycles during beat 3 -> address/control frozen, 8 rd_valid in order, a single done, 2 cycles later than the zero-wait case.
- **INCR16 read with ERROR:** two-cycle ERROR on beat 2 -> htrans = 00 in the second ERROR cycle, rd_valid only for beat 1, done with err = 1, no further beats.
- **Reset mid-burst:** drop hresetn in the middle of an INCR8 write -> outputs take their reset values immediately with no done. After release, a SINGLE read completes normally.
